mips_multicycle_control: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It replaces the single-cycle decoder and override-mux scheme with a sequenced controller over one shared memory port: fetch, decode, execute, memory and writeback each take one or more cycles. Supports R-type ALU ops, `jr`, `jalr`, `addi`, `lw`, `sw`, `beq` and `bne`. Memory uses a variable-latency ready handshake with a parametrised timeout, and illegal instructions or timeouts trap into a sticky fault state.

---
 rtl/mips_multicycle_control.sv | 226 ++++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/writeback
// over one shared memory port with a ready handshake, wait timeout and sticky fault.
module mips_multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter logic [2:0]  ALUOP_ADD   = 3'd2,
   parameter logic [2:0]  ALUOP_SUB   = 3'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic [1:0] PCSrc,
   output logic       IRWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] WBSel,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       inst_done,
   output logic       fault,
   output logic [1:0] fault_cause,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_LD   = 4'd5,
      S_MEM_ST   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP_REG = 4'd10,
      S_FAULT    = 4'd15
   } state_t;

   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     cur, nxt;
   logic [7:0] wait_cnt;
   logic [1:0] cause_q, cause_d;
   logic       r_alu_ok;
   logic [2:0] r_aluop;
   logic       timed_out;
   logic       in_wait;

   assign state       = cur;
   assign fault       = (cur == S_FAULT);
   assign fault_cause = cause_q;
   assign timed_out   = (wait_cnt == WAIT_LAST) && !mem_ready;
   assign in_wait     = (cur == S_FETCH) || (cur == S_MEM_LD) || (cur == S_MEM_ST);

   // R-type funct decode: legality and ALU operation
   always_comb begin
      r_alu_ok = 1'b1;
      r_aluop  = ALUOP_ADD;
      case (funct)
         6'h20:   r_aluop = ALUOP_ADD;
         6'h22:   r_aluop = ALUOP_SUB;
         6'h24:   r_aluop = 3'd4;
         6'h25:   r_aluop = 3'd5;
         6'h26:   r_aluop = 3'd7;
         6'h27:   r_aluop = 3'd6;
         default: r_alu_ok = 1'b0;
      endcase
   end

   // Next-state, fault cause and control outputs
   always_comb begin
      nxt       = cur;
      cause_d   = cause_q;
      PCWrite   = 1'b0;
      PCSrc     = 2'd0;
      IRWrite   = 1'b0;
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      RegDst    = 2'd0;
      WBSel     = 2'd0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 2'd0;
      ALUOp     = ALUOP_ADD;
      inst_done = 1'b0;
      unique case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'd1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               nxt     = S_DECODE;
            end else if (timed_out) begin
               nxt     = S_FAULT;
               cause_d = 2'd2;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'd3;
            if (opcode == 6'h00) begin
               if (r_alu_ok)                            nxt = S_EXEC_R;
               else if (funct == 6'h08 || funct == 6'h09) nxt = S_JUMP_REG;
               else begin
                  nxt     = S_FAULT;
                  cause_d = 2'd1;
               end
            end else begin
               case (opcode)
                  6'h08:        nxt = S_EXEC_I;
                  6'h23, 6'h2b: nxt = S_MEM_ADDR;
                  6'h04, 6'h05: nxt = S_BRANCH;
                  default: begin
                     nxt     = S_FAULT;
                     cause_d = 2'd1;
                  end
               endcase
            end
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd0;
            ALUOp   = r_aluop;
            nxt     = S_WB_ALU;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            nxt     = S_WB_ALU;
         end
         S_WB_ALU: begin
            // IR is stable through writeback, so the opcode identifies the source path
            RegWrite  = 1'b1;
            RegDst    = (opcode == 6'h00) ? 2'd1 : 2'd0;
            inst_done = 1'b1;
            nxt       = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'd2;
            nxt     = (opcode == 6'h23) ? S_MEM_LD : S_MEM_ST;
         end
         S_MEM_LD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) nxt = S_WB_MEM;
            else if (timed_out) begin
               nxt     = S_FAULT;
               cause_d = 2'd2;
            end
         end
         S_WB_MEM: begin
            RegWrite  = 1'b1;
            WBSel     = 2'd1;
            inst_done = 1'b1;
            nxt       = S_FETCH;
         end
         S_MEM_ST: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               inst_done = 1'b1;
               nxt       = S_FETCH;
            end else if (timed_out) begin
               nxt     = S_FAULT;
               cause_d = 2'd2;
            end
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'd0;
            ALUOp     = ALUOP_SUB;
            PCSrc     = 2'd1;
            PCWrite   = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
            inst_done = 1'b1;
            nxt       = S_FETCH;
         end
         S_JUMP_REG: begin
            PCWrite   = 1'b1;
            PCSrc     = 2'd2;
            inst_done = 1'b1;
            if (funct == 6'h09) begin
               RegWrite = 1'b1;
               RegDst   = 2'd2;
               WBSel    = 2'd2;
            end
            nxt = S_FETCH;
         end
         S_FAULT: nxt = S_FAULT;
         default: nxt = S_FETCH;
      endcase
      if (reset) begin
         PCWrite   = 1'b0;
         IRWrite   = 1'b0;
         MemRead   = 1'b0;
         MemWrite  = 1'b0;
         RegWrite  = 1'b0;
         inst_done = 1'b0;
         nxt       = S_FETCH;
         cause_d   = '0;
      end
   end

   // State and fault cause registers
   always_ff @(posedge clk) begin
      cur     <= nxt;
      cause_q <= cause_d;
   end

   // Memory wait counter: cleared on any state change, counts stalled cycles in wait states
   always_ff @(posedge clk) begin
      if (reset)                       wait_cnt <= '0;
      else if (nxt != cur)             wait_cnt <= '0;
      else if (in_wait && !mem_ready)  wait_cnt <= wait_cnt + 8'd1;
   end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction-trace bench for mips_multicycle_control.
module tb_mips_multicycle_control;

   localparam int TO = 4;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic       inst_done;
      logic       fault;
      logic [1:0] fault_cause;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic       z;
      logic [5:0] op;
      logic [5:0] fn;
      logic [3:0] st;
      ctl_t       c;
   } step_t;

   typedef enum int {C_R, C_JR, C_JALR, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_ILL} cls_t;

   logic       clk = 1'b0;
   logic       reset, zero, mem_ready;
   logic [5:0] opcode, funct;
   logic       PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, ALUSrcA, inst_done, fault;
   logic [1:0] PCSrc, RegDst, WBSel, ALUSrcB, fault_cause;
   logic [2:0] ALUOp;
   logic [3:0] state;
   ctl_t       act;

   int    checks = 0, errors = 0;
   int    done_exp = 0, done_seen = 0;
   step_t q[$];
   step_t cur_step;
   bit    cur_valid = 1'b0;
   logic [5:0] cur_op, cur_fn;

   always #5 clk = ~clk;

   mips_multicycle_control #(.MEM_TIMEOUT(TO), .ALUOP_ADD(3'd2), .ALUOP_SUB(3'd3)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
      .RegDst(RegDst), .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .inst_done(inst_done), .fault(fault), .fault_cause(fault_cause),
      .state(state)
   );

   assign act = {PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegWrite, RegDst,
                 WBSel, ALUSrcA, ALUSrcB, ALUOp, inst_done, fault, fault_cause};

   function automatic ctl_t dflt();
      ctl_t c = '0;
      c.alu_op = 3'd2;
      return c;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic cls_t classify(logic [5:0] op, logic [5:0] fn);
      if (op == 6'h00) begin
         case (fn)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27: return C_R;
            6'h08: return C_JR;
            6'h09: return C_JALR;
            default: return C_ILL;
         endcase
      end
      case (op)
         6'h08: return C_ADDI;
         6'h23: return C_LW;
         6'h2b: return C_SW;
         6'h04: return C_BEQ;
         6'h05: return C_BNE;
         default: return C_ILL;
      endcase
   endfunction

   function automatic logic [2:0] r_aluop(logic [5:0] fn);
      case (fn)
         6'h22:   return 3'd3;
         6'h24:   return 3'd4;
         6'h25:   return 3'd5;
         6'h26:   return 3'd7;
         6'h27:   return 3'd6;
         default: return 3'd2;
      endcase
   endfunction

   function automatic int pick_wait();
      return ($urandom_range(0, 11) == 0) ? TO : int'($urandom_range(0, TO - 1));
   endfunction

   task automatic pin(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   task automatic push(input logic [3:0] st, input ctl_t c, input logic rdy, input logic z);
      step_t s;
      s.rst = 1'b0; s.rdy = rdy; s.z = z; s.op = cur_op; s.fn = cur_fn; s.st = st; s.c = c;
      q.push_back(s);
   endtask

   task automatic push_rst();
      step_t s;
      s.rst = 1'b1; s.rdy = rb(); s.z = rb(); s.op = cur_op; s.fn = cur_fn; s.st = 4'd0; s.c = '0;
      q.push_back(s);
   endtask

   task automatic fault_tail(input logic [1:0] cause);
      ctl_t c = dflt();
      c.fault = 1'b1;
      c.fault_cause = cause;
      for (int i = 0; i < 3; i++) push(4'd15, c, rb(), rb());
      push_rst();
   endtask

   // w stalled cycles, then either completion or (w == TO) a timeout fault
   task automatic wait_phase(input logic [3:0] st, input ctl_t cw, input ctl_t cr,
                             input int w, output bit faulted);
      for (int i = 0; i < w; i++) push(st, cw, 1'b0, rb());
      if (w >= TO) begin
         faulted = 1'b1;
         fault_tail(2'd2);
      end else begin
         faulted = 1'b0;
         push(st, cr, 1'b1, rb());
      end
   endtask

   task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                        input int mw, input logic z);
      ctl_t c, cr;
      bit   f;
      cls_t k;
      cur_op = op;
      cur_fn = fn;
      k = classify(op, fn);
      c = dflt(); c.mem_read = 1'b1; c.alu_src_b = 2'd1;
      cr = c; cr.ir_write = 1'b1; cr.pc_write = 1'b1;
      wait_phase(4'd0, c, cr, fw, f);
      if (f) return;
      c = dflt(); c.alu_src_b = 2'd3;
      push(4'd1, c, rb(), rb());
      case (k)
         C_R, C_ADDI: begin
            c = dflt(); c.alu_src_a = 1'b1;
            if (k == C_R) c.alu_op = r_aluop(fn); else c.alu_src_b = 2'd2;
            push((k == C_R) ? 4'd2 : 4'd3, c, rb(), rb());
            c = dflt(); c.reg_write = 1'b1; c.inst_done = 1'b1;
            c.reg_dst = (k == C_R) ? 2'd1 : 2'd0;
            push(4'd7, c, rb(), rb());
         end
         C_LW, C_SW: begin
            c = dflt(); c.alu_src_a = 1'b1; c.alu_src_b = 2'd2;
            push(4'd4, c, rb(), rb());
            c = dflt(); c.iord = 1'b1;
            if (k == C_LW) c.mem_read = 1'b1; else c.mem_write = 1'b1;
            cr = c;
            if (k == C_SW) cr.inst_done = 1'b1;
            wait_phase((k == C_LW) ? 4'd5 : 4'd6, c, cr, mw, f);
            if (!f && k == C_LW) begin
               c = dflt(); c.reg_write = 1'b1; c.wb_sel = 2'd1; c.inst_done = 1'b1;
               push(4'd8, c, rb(), rb());
            end
         end
         C_BEQ, C_BNE: begin
            c = dflt(); c.alu_src_a = 1'b1; c.alu_op = 3'd3; c.pc_src = 2'd1; c.inst_done = 1'b1;
            c.pc_write = (k == C_BEQ) ? z : !z;
            push(4'd9, c, rb(), z);
         end
         C_JR, C_JALR: begin
            c = dflt(); c.pc_write = 1'b1; c.pc_src = 2'd2; c.inst_done = 1'b1;
            if (k == C_JALR) begin
               c.reg_write = 1'b1; c.reg_dst = 2'd2; c.wb_sel = 2'd2;
            end
            push(4'd10, c, rb(), rb());
         end
         default: fault_tail(2'd1);
      endcase
   endtask

   // Driver: applies one trace step per cycle shortly after the rising edge
   task automatic run_q();
      while (q.size() > 0) begin
         step_t s = q.pop_front();
         @(posedge clk);
         #1;
         reset = s.rst; mem_ready = s.rdy; zero = s.z; opcode = s.op; funct = s.fn;
         cur_step = s;
         cur_valid = 1'b1;
      end
   endtask

   // Compare DUT outputs against the current trace step on the falling edge
   always @(negedge clk) begin
      if (cur_valid) begin
         if (cur_step.rst) begin
            checks++;
            if ((act.pc_write | act.ir_write | act.mem_read | act.mem_write |
                 act.reg_write | act.inst_done) !== 1'b0) begin
               errors++;
               $display("FAIL reset_enables: got ctl %h required all enables 0", act);
            end
         end else begin
            checks++;
            if (state !== cur_step.st) begin
               errors++;
               $display("FAIL state: got %0d required %0d", state, cur_step.st);
            end
            checks++;
            if (act !== cur_step.c) begin
               errors++;
               $display("FAIL ctl(st=%0d op=%h fn=%h rdy=%b z=%b): got %h required %h",
                        cur_step.st, cur_step.op, cur_step.fn, cur_step.rdy, cur_step.z,
                        act, cur_step.c);
            end
            if (cur_step.c.inst_done) done_exp++;
         end
         if (act.inst_done === 1'b1) done_seen++;
      end
   end

   logic [5:0] legal_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05};
   logic [5:0] legal_fn [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h08, 6'h09,
                                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

   initial begin
      int n_fetch;
      reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
      cur_op = '0; cur_fn = '0;
      push_rst(); push_rst();
      run_q();

      build(6'h00, 6'h20, 0, 0, 1'b0);            // add
      pin("add_len", q.size(), 4);
      pin("add_exec_state", int'(q[2].st), 2);
      run_q();
      build(6'h23, 6'h00, 0, 3, 1'b0);            // lw with 3 wait cycles
      pin("lw_wait3_len", q.size(), 8);
      run_q();
      build(6'h04, 6'h00, 0, 0, 1'b1);            // beq taken
      pin("beq_len", q.size(), 3);
      run_q();
      build(6'h05, 6'h00, 0, 0, 1'b1);            // bne not taken
      run_q();
      build(6'h00, 6'h09, 0, 0, 1'b0);            // jalr
      pin("jalr_len", q.size(), 3);
      run_q();
      build(6'h00, 6'h08, 0, 0, 1'b0);            // jr
      run_q();
      build(6'h2b, 6'h00, 0, 0, 1'b0);            // sw
      pin("sw_len", q.size(), 4);
      run_q();
      build(6'h3f, 6'h00, 0, 0, 1'b0);            // illegal -> fault cause 1, reset
      run_q();
      build(6'h08, 6'h00, TO, 0, 1'b0);           // fetch timeout
      n_fetch = 0;
      foreach (q[i]) if (q[i].st == 4'd0 && !q[i].rst) n_fetch++;
      pin("timeout_fetch_cycles", n_fetch, 4);
      run_q();
      build(6'h00, 6'h20, TO - 1, 0, 1'b0);       // ready on the last allowed cycle
      run_q();
      build(6'h2b, 6'h00, 0, TO, 1'b0);           // store timeout
      run_q();

      for (int n = 0; n < 300; n++) begin
         int r = $urandom_range(0, 15);
         logic [5:0] op, fn;
         if (r < 13) begin
            op = legal_op[r];
            fn = (op == 6'h00) ? legal_fn[r] : 6'($urandom_range(0, 63));
         end else begin
            op = 6'($urandom_range(0, 63));
            fn = 6'($urandom_range(0, 63));
         end
         build(op, fn, pick_wait(), pick_wait(), rb());
         if ($urandom_range(0, 19) == 0) begin
            int k = $urandom_range(0, q.size() - 1);
            while (q.size() > k) void'(q.pop_back());
            push_rst();
         end
         run_q();
      end

      @(posedge clk);
      #1 cur_valid = 1'b0;
      #10;
      pin("inst_done_count", done_seen, done_exp);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
